// File: rtl/fifo_access_arb.sv
// fifo_access_arb: round-robin arbiter that sequences two write requesters
// and one read requester onto a single FIFO port. At most one FIFO operation
// is issued per cycle. A shadow occupancy count means the FIFO never sees
// a write while full or a read while empty.
module fifo_access_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr0_req,
  input  logic [DATA_WIDTH-1:0] wr0_din,
  output logic                  wr0_gnt,
  input  logic                  wr1_req,
  input  logic [DATA_WIDTH-1:0] wr1_din,
  output logic                  wr1_gnt,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic [CNT_WIDTH-1:0]  occ,
  output logic [2:0]            op_state,
  output logic [2:0]            starve
);

  // Outcome encoding shared with the FIFO.
  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_NO_OP    = 3'b001,
    ST_WRITE    = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_READ     = 3'b100,
    ST_RD_ERROR = 3'b101
  } op_state_t;

  // Round-robin pointer names the most recently granted requester.
  typedef enum logic [1:0] {
    SEL_WR0 = 2'd0,
    SEL_WR1 = 2'd1,
    SEL_RD  = 2'd2
  } sel_t;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
  localparam logic [7:0]           TIMEOUT_C = 8'(TIMEOUT);

  op_state_t             op_state_reg, op_state_next;
  sel_t                  ptr_reg, ptr_next;
  logic                  fifo_wr_en_reg, fifo_rd_en_reg;
  logic [DATA_WIDTH-1:0] fifo_din_reg;
  logic [CNT_WIDTH-1:0]  occ_reg;
  logic [2:0]            starve_reg;
  logic [2:0]            starve_set;

  logic [2:0] req_vec;   // {rd, wr1, wr0}
  logic [2:0] elig;
  logic [2:0] gnt;
  logic       is_full, is_empty;
  logic       wr_gnt_any;

  assign is_full    = (occ_reg == DEPTH_C);
  assign is_empty   = (occ_reg == '0);
  assign req_vec    = {rd_req, wr1_req, wr0_req};
  assign elig       = {rd_req & ~is_empty, wr1_req & ~is_full, wr0_req & ~is_full};
  assign wr_gnt_any = gnt[0] | gnt[1];

  // Grant the first eligible requester after the one granted last.
  always_comb begin
    gnt = 3'b000;
    case (ptr_reg)
      SEL_WR0: begin
        if      (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
      end
      SEL_WR1: begin
        if      (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
      end
      default: begin
        if      (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
      end
    endcase
  end

  assign wr0_gnt = gnt[0];
  assign wr1_gnt = gnt[1];
  assign rd_gnt  = gnt[2];

  // Pointer advances only on a transfer; otherwise it holds.
  always_comb begin
    ptr_next = ptr_reg;
    if      (gnt[0]) ptr_next = SEL_WR0;
    else if (gnt[1]) ptr_next = SEL_WR1;
    else if (gnt[2]) ptr_next = SEL_RD;
  end

  // Outcome of this cycle; INIT is left on the first request ever seen.
  always_comb begin
    op_state_next = ST_NO_OP;
    if (op_state_reg == ST_INIT && req_vec == 3'b000) op_state_next = ST_INIT;
    else if (gnt[2])                                  op_state_next = ST_READ;
    else if (wr_gnt_any)                              op_state_next = ST_WRITE;
    else if (rd_req && is_empty)                      op_state_next = ST_RD_ERROR;
    else if ((wr0_req || wr1_req) && is_full)         op_state_next = ST_WR_ERROR;
  end

  // Outcome state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) op_state_reg <= ST_INIT;
    else          op_state_reg <= op_state_next;
  end

  // FIFO command pipeline, shadow occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr_en_reg <= 1'b0;
      fifo_rd_en_reg <= 1'b0;
      fifo_din_reg   <= '0;
      occ_reg        <= '0;
      ptr_reg        <= SEL_RD;
    end else begin
      fifo_wr_en_reg <= wr_gnt_any;
      fifo_rd_en_reg <= gnt[2];
      ptr_reg        <= ptr_next;
      if (gnt[0])      fifo_din_reg <= wr0_din;
      else if (gnt[1]) fifo_din_reg <= wr1_din;
      if (wr_gnt_any)  occ_reg <= occ_reg + 1'b1;
      else if (gnt[2]) occ_reg <= occ_reg - 1'b1;
    end
  end

  // Per-requester wait counters that flag starvation at TIMEOUT.
  for (genvar gi = 0; gi < 3; gi++) begin : g_wait
    logic [7:0] wait_reg, wait_next;

    // Count ungranted request cycles, saturating at TIMEOUT.
    always_comb begin
      wait_next = wait_reg;
      if (!req_vec[gi] || gnt[gi]) wait_next = '0;
      else if (wait_reg < TIMEOUT_C) wait_next = wait_reg + 8'd1;
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wait_reg <= '0;
      else          wait_reg <= wait_next;
    end

    assign starve_set[gi] = (wait_next == TIMEOUT_C);
  end

  // Sticky starvation flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_reg <= 3'b000;
    else          starve_reg <= starve_reg | starve_set;
  end

  assign fifo_wr_en = fifo_wr_en_reg;
  assign fifo_rd_en = fifo_rd_en_reg;
  assign fifo_din   = fifo_din_reg;
  assign occ        = occ_reg;
  assign op_state   = op_state_reg;
  assign starve     = starve_reg;

endmodule

// File: tb/tb_fifo_access_arb.sv
// Directed testbench for fifo_access_arb: linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_fifo_access_arb;

  localparam int DW = 32;

  localparam logic [2:0] OP_INIT     = 3'b000;
  localparam logic [2:0] OP_NO_OP    = 3'b001;
  localparam logic [2:0] OP_WRITE    = 3'b010;
  localparam logic [2:0] OP_WR_ERROR = 3'b011;
  localparam logic [2:0] OP_READ     = 3'b100;
  localparam logic [2:0] OP_RD_ERROR = 3'b101;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr0_req = 1'b0;
  logic [DW-1:0] wr0_din = '0;
  logic          wr0_gnt;
  logic          wr1_req = 1'b0;
  logic [DW-1:0] wr1_din = '0;
  logic          wr1_gnt;
  logic          rd_req = 1'b0;
  logic          rd_gnt;
  logic          fifo_wr_en;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_din;
  logic [3:0]    occ;
  logic [2:0]    op_state;
  logic [2:0]    starve;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  fifo_access_arb #(
    .DATA_WIDTH(DW),
    .DEPTH(8),
    .CNT_WIDTH(4),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr0_req(wr0_req),
    .wr0_din(wr0_din),
    .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req),
    .wr1_din(wr1_din),
    .wr1_gnt(wr1_gnt),
    .rd_req(rd_req),
    .rd_gnt(rd_gnt),
    .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en),
    .fifo_din(fifo_din),
    .occ(occ),
    .op_state(op_state),
    .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, rd_gnt, wr1_gnt, wr0_gnt}, {29'd0, exp});
  endtask

  task automatic exp_regs(input string tag, input logic wr_en, input logic rd_en,
                          input logic [3:0] exp_occ, input logic [2:0] exp_op);
    check({tag, "_wr_en"}, {31'd0, fifo_wr_en}, {31'd0, wr_en});
    check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, {31'd0, rd_en});
    check({tag, "_occ"}, {28'd0, occ}, {28'd0, exp_occ});
    check({tag, "_op"}, {29'd0, op_state}, {29'd0, exp_op});
  endtask

  logic [2:0]  rot_gnt [4];
  logic [3:0]  rot_occ [4];

  initial begin
    rot_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    rot_occ = '{4'd3, 4'd4, 4'd3, 4'd4};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    exp_regs("rst", 1'b0, 1'b0, 4'd0, OP_INIT);
    check("rst_din", fifo_din, 32'h0);
    check("rst_starve", {29'd0, starve}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_init", {29'd0, op_state}, {29'd0, OP_INIT});

    // Single write from wr0
    wr0_req = 1'b1; wr0_din = 32'hA5;
    #1;
    exp_gnt("t1_gnt", 3'b001);
    tick();
    wr0_req = 1'b0;
    #1;
    exp_regs("t1", 1'b1, 1'b0, 4'd1, OP_WRITE);
    check("t1_din", fifo_din, 32'hA5);
    tick();
    exp_regs("t1_pulse", 1'b0, 1'b0, 4'd1, OP_NO_OP);

    // Bring occupancy to 2 with pointer back at rd
    wr1_req = 1'b1; wr1_din = 32'h11;
    #1;
    exp_gnt("prep_wr1_gnt", 3'b010);
    tick();
    wr1_req = 1'b0;
    #1;
    check("prep_wr1_din", fifo_din, 32'h11);
    wr0_req = 1'b1; wr0_din = 32'h22;
    #1;
    exp_gnt("prep_wr0_gnt", 3'b001);
    tick();
    wr0_req = 1'b0;
    rd_req = 1'b1;
    #1;
    exp_gnt("prep_rd_gnt", 3'b100);
    tick();
    rd_req = 1'b0;
    #1;
    exp_regs("prep", 1'b0, 1'b1, 4'd2, OP_READ);

    // All three requesting: strict rotation wr0, wr1, rd, wr0
    wr0_req = 1'b1; wr0_din = 32'hB0;
    wr1_req = 1'b1; wr1_din = 32'hB1;
    rd_req  = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_gnt($sformatf("rot%0d_gnt", i), rot_gnt[i]);
      tick();
      if (i == 3) begin
        wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
      end
      #1;
      check($sformatf("rot%0d_occ", i), {28'd0, occ}, {28'd0, rot_occ[i]});
      check($sformatf("rot%0d_excl", i), {31'd0, fifo_wr_en & fifo_rd_en}, 32'd0);
      check($sformatf("rot%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, rot_gnt[i][2]});
      if (rot_gnt[i][0]) check($sformatf("rot%0d_din", i), fifo_din, 32'hB0);
      if (rot_gnt[i][1]) check($sformatf("rot%0d_din", i), fifo_din, 32'hB1);
    end

    // Fill to full with wr1, then starve it
    wr1_req = 1'b1; wr1_din = 32'hC1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_gnt($sformatf("fill%0d_gnt", i), 3'b010);
      tick();
      check($sformatf("fill%0d_occ", i), {28'd0, occ}, 32'(5 + i));
    end
    #1;
    exp_gnt("full_gnt", 3'b000);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1)  exp_regs("full", 1'b0, 1'b0, 4'd8, OP_WR_ERROR);
      if (k == 14) check("starve_pre", {29'd0, starve}, 32'd0);
      if (k == 15) check("starve_set", {29'd0, starve}, 32'b010);
    end
    rd_req = 1'b1;
    #1;
    exp_gnt("full_rd_gnt", 3'b100);
    tick();
    rd_req = 1'b0; wr1_req = 1'b0;
    #1;
    exp_regs("full_rd", 1'b0, 1'b1, 4'd7, OP_READ);
    tick();
    check("starve_sticky", {29'd0, starve}, 32'b010);

    // Reset, then read on empty and write-before-read
    #2;
    reset_n = 1'b0;
    #1;
    exp_regs("rst2", 1'b0, 1'b0, 4'd0, OP_INIT);
    check("rst2_starve", {29'd0, starve}, 32'd0);
    tick();
    reset_n = 1'b1;
    rd_req = 1'b1;
    #1;
    exp_gnt("empty_rd_gnt", 3'b000);
    tick();
    exp_regs("empty_rd", 1'b0, 1'b0, 4'd0, OP_RD_ERROR);
    wr0_req = 1'b1; wr0_din = 32'hD0;
    #1;
    exp_gnt("empty_wr_gnt", 3'b001);
    tick();
    wr0_req = 1'b0;
    #1;
    exp_regs("empty_wr", 1'b1, 1'b0, 4'd1, OP_WRITE);
    exp_gnt("after_wr_rd_gnt", 3'b100);
    tick();
    rd_req = 1'b0;
    #1;
    exp_regs("after_wr_rd", 1'b0, 1'b1, 4'd0, OP_READ);

    // Reset in the cycle after a grant
    wr0_req = 1'b1; wr0_din = 32'hE0;
    #1;
    exp_gnt("mid_gnt", 3'b001);
    tick();
    wr0_req = 1'b0;
    #1;
    exp_regs("mid_pre", 1'b1, 1'b0, 4'd1, OP_WRITE);
    reset_n = 1'b0;
    #1;
    exp_regs("mid_rst", 1'b0, 1'b0, 4'd0, OP_INIT);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_regs($sformatf("post_rst%0d", i), 1'b0, 1'b0, 4'd0, OP_INIT);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_access_arb.md
Name: fifo_access_arb

Overview:
- Three-way arbiter and sequencer in front of the 8-entry FIFO. Its clients are two write requesters (wr0, wr1) and one read requester (rd).
- Grants at most one FIFO operation per cycle, using round-robin order. It never drives fifo_wr_en and fifo_rd_en high together, so the FIFO's simultaneous-request NO_OP path is never used.
- Keeps a shadow occupancy count so it never writes when full and never reads when empty.
- Reports the last cycle's outcome with the same 3-bit state encoding the FIFO uses.

Parameters:
- DATA_WIDTH, 32, width of write data.
- DEPTH, 8, FIFO capacity in entries.
- CNT_WIDTH, 4, occupancy width; must hold 0..DEPTH.
- TIMEOUT, 15, number of consecutive un-granted request cycles before a starvation flag is raised (1..255).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wr0_req  in  1  requester 0 write valid
- wr0_din  in  DATA_WIDTH  requester 0 write data
- wr0_gnt  out  1  requester 0 ready (combinational)
- wr1_req  in  1  requester 1 write valid
- wr1_din  in  DATA_WIDTH  requester 1 write data
- wr1_gnt  out  1  requester 1 ready (combinational)
- rd_req  in  1  read request
- rd_gnt  out  1  read ready (combinational)
- fifo_wr_en  out  1  registered FIFO write enable
- fifo_rd_en  out  1  registered FIFO read enable
- fifo_din  out  DATA_WIDTH  registered FIFO write data
- occ  out  CNT_WIDTH  shadow occupancy
- op_state  out  3  last-cycle outcome: INIT 000, NO_OP 001, WRITE 010, WR_ERROR 011, READ 100, RD_ERROR 101
- starve  out  3  sticky starvation flags; bit0 = wr0, bit1 = wr1, bit2 = rd

Behaviour:
- Reset (async, reset_n=0) forces the following values:
  - fifo_wr_en=0, fifo_rd_en=0, fifo_din=0, occ=0.
  - op_state=INIT, starve=000.
  - RR pointer=RD, so the first priority order is wr0 > wr1 > rd.
  - All wait counters=0.
  - Mid-operation reset discards any pending grant; no FIFO enable is issued after reset deasserts until a new grant.
- Eligibility:
  - wr0 is eligible when wr0_req=1 and occ<DEPTH.
  - wr1 is eligible when wr1_req=1 and occ<DEPTH.
  - rd is eligible when rd_req=1 and occ>0.
- Grant (combinational, one-hot or zero):
  - Scan the order starting at the requester after the RR pointer: wr0 -> wr1 -> rd -> wr0.
  - Grant the first eligible requester.
  - A transfer occurs at the rising edge where req and gnt are both high.
  - A requester may hold req high for back-to-back transfers.
  - A requester must keep req and its data stable until it is granted.
- At each edge with a transfer:
  - RR pointer moves to the granted requester.
  - Write grant: fifo_wr_en=1, fifo_din=granted din, fifo_rd_en=0, occ+1.
  - Read grant: fifo_rd_en=1, fifo_wr_en=0, occ-1.
- At each edge with no transfer: both enables=0; occ and pointer hold.
- Latency: grant to FIFO enable is exactly 1 cycle. Enables are single-cycle pulses per transfer.
- occ never exceeds DEPTH and never underflows. Wrap-around cannot occur by construction.
- op_state is registered and updated every edge, using the first matching rule:
  1. If it was INIT and no req is high: stay INIT.
  2. Read granted: READ.
  3. Write granted: WRITE.
  4. rd_req=1 with occ=0: RD_ERROR.
  5. Any write req with occ=DEPTH: WR_ERROR.
  6. Otherwise: NO_OP.
- op_state leaves INIT on the first cycle any req is high and never returns to INIT except on reset.
- Simultaneous events:
  - Both writers plus the reader requesting: rotate strictly, one grant per cycle.
  - Full with rd_req high: the read is granted; writers wait.
  - Empty with writes requested: the write is granted; rd waits.
- Starvation:
  - Each requester has an 8-bit wait counter.
  - The counter increments while req=1 and gnt=0, saturating at TIMEOUT.
  - It clears when gnt=1 or req=0.
  - When a counter reaches TIMEOUT, its starve bit sets and stays set until reset.

Test Plan:
- Reset, then wr0_req=1 with din=0xA5 for 1 cycle -> wr0_gnt=1 combinationally; next cycle fifo_wr_en=1, fifo_din=0xA5, occ=1, op_state=WRITE.
- wr0_req, wr1_req and rd_req all held high with occ=2 -> grants rotate wr0, wr1, rd, wr0, ...; fifo_wr_en and fifo_rd_en are never high together; occ goes 3, 4, 3, 4.
- Fill to occ=8 with wr1_req held high and rd_req=0 -> wr1_gnt=0, op_state=WR_ERROR, occ stays 8; after 15 cycles starve=010. Then raise rd_req -> rd_gnt=1, occ=7, op_state=READ.
- After reset, rd_req=1 with occ=0 -> rd_gnt=0, op_state=RD_ERROR, no fifo_rd_en. Then wr0_req=1 -> write granted; next cycle rd is granted; occ returns to 0.
- Assert reset_n=0 in the cycle after a grant -> fifo_wr_en drops immediately, occ=0, op_state=INIT, starve=000. With no requests after release, op_state stays INIT.
